// File: rtl/next_state_sequencer_pkg.sv
// Shared control-unit definitions: state width, ns_sel encodings and the
// reset/fetch state defaults used by the encoder, microstore and sequencer.
package next_state_sequencer_pkg;

    localparam int CU_STATE_W     = 10;
    localparam int CU_RESET_STATE = 0;
    localparam int CU_FETCH_STATE = 1;

    localparam logic [2:0] NS_ENCODE   = 3'd0;
    localparam logic [2:0] NS_INCR     = 3'd1;
    localparam logic [2:0] NS_JUMP     = 3'd2;
    localparam logic [2:0] NS_CBRANCH  = 3'd3;
    localparam logic [2:0] NS_WAIT_MOC = 3'd4;
    localparam logic [2:0] NS_FETCH    = 3'd5;

endpackage

// File: rtl/next_state_sequencer_mux.sv
// Combinational next-state selection from the microinstruction ns_sel field.
// Codes 6 and 7 fall back to FETCH_STATE and raise illegal.
module next_state_mux
    import next_state_sequencer_pkg::*;
#(
    parameter int STATE_W     = CU_STATE_W,
    parameter int FETCH_STATE = CU_FETCH_STATE
) (
    input  logic [STATE_W-1:0] state,
    input  logic [STATE_W-1:0] encoder_state,
    input  logic [STATE_W-1:0] cr_addr,
    input  logic [2:0]         ns_sel,
    input  logic               inv,
    input  logic               cond,
    input  logic               moc,
    output logic [STATE_W-1:0] next_state,
    output logic               illegal
);

    logic [STATE_W-1:0] state_inc;

    // Natural width truncation gives the required modulo-2^STATE_W wrap.
    assign state_inc = state + {{(STATE_W-1){1'b0}}, 1'b1};

    always_comb begin
        next_state = STATE_W'(FETCH_STATE);
        illegal    = 1'b0;
        case (ns_sel)
            NS_ENCODE:   next_state = encoder_state;
            NS_INCR:     next_state = state_inc;
            NS_JUMP:     next_state = cr_addr;
            NS_CBRANCH:  next_state = (cond ^ inv) ? cr_addr : state_inc;
            NS_WAIT_MOC: next_state = moc ? state_inc : state;
            NS_FETCH:    next_state = STATE_W'(FETCH_STATE);
            default: begin
                next_state = STATE_W'(FETCH_STATE);
                illegal    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/next_state_sequencer.sv
// Control-state register, sticky illegal-select flag and optional MOC wait
// timeout (enabled by defining MOC_TIMEOUT_EN) around next_state_mux.
module next_state_sequencer
    import next_state_sequencer_pkg::*;
#(
    parameter int STATE_W     = CU_STATE_W,
    parameter int RESET_STATE = CU_RESET_STATE,
    parameter int FETCH_STATE = CU_FETCH_STATE
`ifdef MOC_TIMEOUT_EN
    ,
    parameter int ABORT_STATE    = 1023,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [STATE_W-1:0] encoder_state,
    input  logic [STATE_W-1:0] cr_addr,
    input  logic [2:0]         ns_sel,
    input  logic               inv,
    input  logic               cond,
    input  logic               moc,
    output logic [STATE_W-1:0] state,
    output logic               wait_active,
    output logic               illegal_sel,
    output logic               mem_timeout
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [STATE_W-1:0] mux_next;
    logic               mux_illegal;
    logic               illegal_sel_q;

    next_state_mux #(
        .STATE_W     (STATE_W),
        .FETCH_STATE (FETCH_STATE)
    ) u_mux (
        .state         (state_q),
        .encoder_state (encoder_state),
        .cr_addr       (cr_addr),
        .ns_sel        (ns_sel),
        .inv           (inv),
        .cond          (cond),
        .moc           (moc),
        .next_state    (mux_next),
        .illegal       (mux_illegal)
    );

    assign wait_active = (ns_sel == NS_WAIT_MOC) && !moc;

`ifdef MOC_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;
    logic             mem_timeout_q;
    logic             mem_timeout_d;

    // A moc arriving on the expiry edge leaves wait_active low, so moc wins.
    always_comb begin
        state_d       = mux_next;
        wait_cnt_d    = '0;
        mem_timeout_d = 1'b0;
        if (wait_active) begin
            if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                state_d       = STATE_W'(ABORT_STATE);
                mem_timeout_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign mem_timeout = mem_timeout_q;
`else
    assign state_d     = mux_next;
    assign mem_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= STATE_W'(RESET_STATE);
            illegal_sel_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            illegal_sel_q <= illegal_sel_q | mux_illegal;
        end
    end

    assign state       = state_q;
    assign illegal_sel = illegal_sel_q;

endmodule

// File: tb/tb_next_state_sequencer.sv
// Directed bench for next_state_sequencer; the timeout steps run only when
// MOC_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYCLES=4).
module tb_next_state_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] encoder_state = '0;
    logic [9:0] cr_addr = '0;
    logic [2:0] ns_sel = 3'd1;
    logic       inv = 1'b0;
    logic       cond = 1'b0;
    logic       moc = 1'b0;
    logic [9:0] state;
    logic       wait_active;
    logic       illegal_sel;
    logic       mem_timeout;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

`ifdef MOC_TIMEOUT_EN
    localparam int HOLD_EDGES = 3;
    next_state_sequencer #(.TIMEOUT_CYCLES(4)) dut (
`else
    localparam int HOLD_EDGES = 5;
    next_state_sequencer dut (
`endif
        .clk           (clk),
        .reset         (reset),
        .encoder_state (encoder_state),
        .cr_addr       (cr_addr),
        .ns_sel        (ns_sel),
        .inv           (inv),
        .cond          (cond),
        .moc           (moc),
        .state         (state),
        .wait_active   (wait_active),
        .illegal_sel   (illegal_sel),
        .mem_timeout   (mem_timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
        $display("check %-20s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    // Advance one edge; sample 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic jump_to(input logic [9:0] target);
        ns_sel  = 3'd2;
        cr_addr = target;
        tick();
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        check("reset_state", 32'(state), 32'd0);
        check("reset_illegal", 32'(illegal_sel), 32'd0);
        check("reset_timeout", 32'(mem_timeout), 32'd0);
        reset = 1'b0;

        // Asynchronous reset between edges
        jump_to(10'd5);
        check("jump_5", 32'(state), 32'd5);
        #2 reset = 1'b1;
        #1 check("async_reset", 32'(state), 32'd0);
        #1 reset = 1'b0;

        // FETCH then ENCODE
        ns_sel = 3'd5;
        tick();
        check("fetch", 32'(state), 32'd1);
        ns_sel = 3'd0;
        encoder_state = 10'd37;
        cr_addr = 10'd999;
        tick();
        check("encode_37", 32'(state), 32'd37);

        // INCR with wrap; cr_addr must be ignored
        jump_to(10'd1022);
        ns_sel = 3'd1;
        cr_addr = 10'd7;
        tick();
        check("incr_1023", 32'(state), 32'd1023);
        tick();
        check("incr_wrap_0", 32'(state), 32'd0);

        // Conditional branch
        jump_to(10'd40);
        ns_sel = 3'd3; cr_addr = 10'd200; cond = 1'b1; inv = 1'b0;
        tick();
        check("cbr_c1_i0", 32'(state), 32'd200);
        jump_to(10'd40);
        ns_sel = 3'd3; cr_addr = 10'd200; cond = 1'b1; inv = 1'b1;
        tick();
        check("cbr_c1_i1", 32'(state), 32'd41);
        jump_to(10'd40);
        ns_sel = 3'd3; cr_addr = 10'd200; cond = 1'b0; inv = 1'b1;
        tick();
        check("cbr_c0_i1", 32'(state), 32'd200);
        jump_to(10'd40);
        ns_sel = 3'd3; cr_addr = 10'd200; cond = 1'b0; inv = 1'b0;
        tick();
        check("cbr_c0_i0", 32'(state), 32'd41);

        // Wait for MOC
        jump_to(10'd50);
        ns_sel = 3'd4; moc = 1'b0;
        #1 check("wait_act_comb", 32'(wait_active), 32'd1);
        for (int i = 0; i < HOLD_EDGES; i++) begin
            tick();
            check("wait_hold", 32'(state), 32'd50);
            check("wait_active_hold", 32'(wait_active), 32'd1);
        end
        check("wait_no_timeout", 32'(mem_timeout), 32'd0);
        moc = 1'b1;
        #1 check("wait_act_moc", 32'(wait_active), 32'd0);
        tick();
        check("wait_done_51", 32'(state), 32'd51);
        moc = 1'b0;

        // Illegal select: sticky until reset
        jump_to(10'd12);
        check("illegal_pre", 32'(illegal_sel), 32'd0);
        ns_sel = 3'd7;
        tick();
        check("illegal_state", 32'(state), 32'd1);
        check("illegal_flag", 32'(illegal_sel), 32'd1);
        ns_sel = 3'd1;
        tick();
        check("illegal_incr", 32'(state), 32'd2);
        check("illegal_sticky", 32'(illegal_sel), 32'd1);
        ns_sel = 3'd6;
        tick();
        check("illegal6_state", 32'(state), 32'd1);
        #2 reset = 1'b1;
        #1 check("illegal_cleared", 32'(illegal_sel), 32'd0);
        #1 reset = 1'b0;

`ifdef MOC_TIMEOUT_EN
        // Timeout expires on the 4th consecutive wait edge
        jump_to(10'd50);
        ns_sel = 3'd4; moc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_hold", 32'(state), 32'd50);
            check("to_no_pulse", 32'(mem_timeout), 32'd0);
        end
        tick();
        check("to_abort", 32'(state), 32'd1023);
        check("to_pulse", 32'(mem_timeout), 32'd1);
        ns_sel = 3'd5;
        tick();
        check("to_pulse_end", 32'(mem_timeout), 32'd0);
        check("to_refetch", 32'(state), 32'd1);

        // moc on the expiry edge wins
        jump_to(10'd50);
        ns_sel = 3'd4; moc = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        moc = 1'b1;
        tick();
        check("to_moc_wins", 32'(state), 32'd51);
        check("to_moc_no_pulse", 32'(mem_timeout), 32'd0);
        moc = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
